// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the run detector. It accepts WIDTH-bit words on valid/ready and emits one bit per clock on x.
// A one-word holding register allows streaming without bubbles. Define SERIAL_FEEDER_LSB_FIRST_EN to send words LSB first.
module serial_bit_feeder #(
  parameter int WIDTH = 16,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done,
  output logic [7:0]       frame_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = 4;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GCNT_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hreg_q, hreg_d;
  logic             hvalid_q, hvalid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [7:0]       frame_q, frame_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             word_done_q, word_done_d;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] sreg_shifted;
  logic             out_bit;

`ifdef SERIAL_FEEDER_LSB_FIRST_EN
  assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
  assign out_bit      = sreg_d[0];
`else
  assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
  assign out_bit      = sreg_d[WIDTH-1];
`endif

  // Load and accept are mutually exclusive: load needs hvalid=1 and accept needs hvalid=0.
  assign accept = din_valid && !hvalid_q;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    hreg_d   = hreg_q;
    hvalid_d = hvalid_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    frame_d  = frame_q;
    load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hvalid_q) load = 1'b1;
      end
      S_SHIFT: begin
        sreg_d = sreg_shifted;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          frame_d = frame_q + 8'd1;
          cnt_d   = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = '0;
          end else if (hvalid_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + GW'(1);
        if (gcnt_q == GCNT_LAST) begin
          gcnt_d = '0;
          if (hvalid_q) load = 1'b1;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      sreg_d   = hreg_q;
      hvalid_d = 1'b0;
      cnt_d    = '0;
      state_d  = S_SHIFT;
    end

    if (accept) begin
      hreg_d   = din;
      hvalid_d = 1'b1;
    end
  end

  // The outputs are registered. They are computed from the next-state values, so each flop holds the bit for its own cycle.
  always_comb begin
    x_valid_d   = (state_d == S_SHIFT);
    x_d         = x_valid_d && out_bit;
    word_done_d = x_valid_d && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      hreg_q      <= '0;
      hvalid_q    <= 1'b0;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      frame_q     <= '0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hreg_q      <= hreg_d;
      hvalid_q    <= hvalid_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      frame_q     <= frame_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign din_ready = !hvalid_q;
  assign busy      = (state_q != S_IDLE) || hvalid_q;
  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign word_done = word_done_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Randomized and directed bench for serial_bit_feeder. It uses two instances, one with GAP=0 and one with GAP=3.
// A timeline model predicts the outputs of every cycle from the handshake and transfer edge arithmetic.
module tb_serial_bit_feeder;
  localparam int W    = 16;
  localparam int MAXN = 300;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy0, x0, xv0, busy0, wd0;
  logic [7:0]   fc0;
  logic         rdy3, x3, xv3, busy3, wd3;
  logic [7:0]   fc3;
  logic [12:0]  dv0, dv3;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy0),
    .x(x0), .x_valid(xv0), .busy(busy0), .word_done(wd0), .frame_cnt(fc0));

  serial_bit_feeder #(.WIDTH(W), .GAP(3)) u_g3 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy3),
    .x(x3), .x_valid(xv3), .busy(busy3), .word_done(wd3), .frame_cnt(fc3));

  assign dv0 = {x0, xv0, wd0, rdy0, busy0, fc0};
  assign dv3 = {x3, xv3, wd3, rdy3, busy3, fc3};

  int nvec = 0;
  int nerr = 0;
  int gap_cur = 0;

  logic [W-1:0] words [MAXN];
  int dly [MAXN];
  int offr [MAXN];
  int acc [MAXN];
  int trn [MAXN];
  int nw;

  function automatic logic [12:0] dut_vec();
    return (gap_cur == 3) ? dv3 : dv0;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Edge arithmetic: word i is offered at offr, accepted at acc and moved into the shifter at trn.
  function automatic void build_model();
    for (int i = 0; i < nw; i++) begin
      if (i == 0) begin
        offr[i] = dly[i];
        acc[i]  = offr[i];
        trn[i]  = acc[i] + 1;
      end else begin
        offr[i] = acc[i-1] + 1 + dly[i];
        acc[i]  = imax(offr[i], trn[i-1] + 1);
        trn[i]  = imax(acc[i] + 1, trn[i-1] + W + gap_cur);
      end
    end
  endfunction

  // Expected {x, x_valid, word_done, din_ready, busy, frame_cnt} during the cycle after edge e.
  function automatic logic [12:0] exp_vec(int e);
    logic xb, xv, wd, rdy, bsy;
    int   fc, k;
    xb = 0; xv = 0; wd = 0; rdy = 1; bsy = 0; fc = 0;
    for (int i = 0; i < nw; i++) begin
      if (e >= trn[i] && e <= trn[i] + W - 1) begin
        k  = e - trn[i];
        xv = 1'b1;
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        xb = words[i][k];
`else
        xb = words[i][W-1-k];
`endif
        wd = (k == W - 1);
      end
      if (e >= acc[i] && e < trn[i]) rdy = 1'b0;
      if (e >= trn[i] && e <= trn[i] + W - 1 + gap_cur) bsy = 1'b1;
      if (e >= trn[i] + W) fc++;
    end
    if (!rdy) bsy = 1'b1;
    return {xb, xv, wd, rdy, bsy, 8'(fc)};
  endfunction

  function automatic int last_cycle();
    return trn[nw-1] + W + gap_cur + 4;
  endfunction

  // Drive the inputs sampled at edge e, then wait for the negedge after that edge.
  task automatic step(input int e);
    int idx;
    idx = -1;
    for (int j = 0; j < nw; j++)
      if (e >= offr[j] && e <= acc[j]) idx = j;
    if (idx >= 0) begin
      din_valid = 1'b1;
      din       = words[idx];
    end else begin
      din_valid = 1'b0;
      din       = W'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    #1;
    nvec++;
    if (dv0 !== 13'b0_0_0_1_0_00000000) begin
      nerr++;
      $display("FAIL reset_g0: got %b want %b", dv0, 13'b0_0_0_1_0_00000000);
    end
    nvec++;
    if (dv3 !== 13'b0_0_0_1_0_00000000) begin
      nerr++;
      $display("FAIL reset_g3: got %b want %b", dv3, 13'b0_0_0_1_0_00000000);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    gap_cur = 0; nw = 1;
    words[0] = 16'h1E39; dly[0] = 0;
    do_reset(); build_model();
    for (int e = 0; e < last_cycle(); e++) begin
      step(e);
      nvec++;
      if (dut_vec() !== exp_vec(e)) begin
        nerr++;
        $display("FAIL single cyc %0d: got %b want %b", e, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    gap_cur = 0; nw = 2;
    words[0] = 16'hFFFF; words[1] = 16'h0000; dly[0] = 0; dly[1] = 0;
    do_reset(); build_model();
    for (int e = 0; e < last_cycle(); e++) begin
      step(e);
      nvec++;
      if (dut_vec() !== exp_vec(e)) begin
        nerr++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", e, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_gap();
    gap_cur = 3; nw = 2;
    words[0] = 16'hAAAA; words[1] = 16'h5555; dly[0] = 0; dly[1] = 0;
    do_reset(); build_model();
    for (int e = 0; e < last_cycle(); e++) begin
      step(e);
      nvec++;
      if (dut_vec() !== exp_vec(e)) begin
        nerr++;
        $display("FAIL gap3 cyc %0d: got %b want %b", e, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    gap_cur = 0; nw = 2;
    words[0] = 16'h1E39; words[1] = 16'h1234; dly[0] = 0; dly[1] = 0;
    do_reset(); build_model();
    // Seven bits are shifted out (cycles after edges 1..7) while 16'h1234 is held.
    for (int e = 0; e <= 7; e++) begin
      step(e);
      nvec++;
      if (dut_vec() !== exp_vec(e)) begin
        nerr++;
        $display("FAIL reset_mid_pre cyc %0d: got %b want %b", e, dut_vec(), exp_vec(e));
      end
    end
    reset     = 1'b1;
    din_valid = 1'b0;
    #1;
    nvec++;
    if (dv0 !== 13'b0_0_0_1_0_00000000) begin
      nerr++;
      $display("FAIL reset_mid_abort: got %b want %b", dv0, 13'b0_0_0_1_0_00000000);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      din = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      nvec++;
      if (dv0 !== 13'b0_0_0_1_0_00000000) begin
        nerr++;
        $display("FAIL reset_mid_quiet cyc %0d: got %b want %b", c, dv0, 13'b0_0_0_1_0_00000000);
      end
    end
    nw = 1; words[0] = 16'hC3A5; dly[0] = 2;
    build_model();
    for (int e = 0; e < last_cycle(); e++) begin
      step(e);
      nvec++;
      if (dut_vec() !== exp_vec(e)) begin
        nerr++;
        $display("FAIL reset_mid_post cyc %0d: got %b want %b", e, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_wrap();
    gap_cur = 0; nw = 256;
    for (int i = 0; i < nw; i++) begin
      words[i] = 16'h0001;
      dly[i]   = 0;
    end
    do_reset(); build_model();
    for (int e = 0; e < last_cycle(); e++) begin
      step(e);
      nvec++;
      if (dut_vec() !== exp_vec(e)) begin
        nerr++;
        $display("FAIL wrap cyc %0d: got %b want %b", e, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_random(input int g);
    gap_cur = g; nw = 40;
    for (int i = 0; i < nw; i++) begin
      words[i] = W'($urandom);
      dly[i]   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 24));
    end
    do_reset(); build_model();
    for (int e = 0; e < last_cycle(); e++) begin
      step(e);
      nvec++;
      if (dut_vec() !== exp_vec(e)) begin
        nerr++;
        $display("FAIL random_g%0d cyc %0d: got %b want %b", g, e, dut_vec(), exp_vec(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_wrap();
    test_random(0);
    test_random(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
